// File: rtl/float_add_arbiter.sv
// -----------------------------------------------------------------------------
// float_add_arbiter
//
// Round-robin scheduler that shares a single float_add_pipeline between
// num_clients requesters. One add is in flight at a time. The winner's operands
// are latched and a one-cycle fa_req is issued. The arbiter then waits for
// fa_ack and returns fa_out to the winner, together with a one-cycle cli_ack.
//
// Optional feature, enabled by defining FLOAT_ARB_TIMEOUT_EN:
//   A watchdog bounds the WAIT state to timeout_cycles cycles. On expiry it
//   pulses cli_err for the granted client instead of cli_ack. When the macro
//   is undefined, no counter is built and cli_err is tied to 0.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   rst      in   synchronous active-low reset
//   cli_req  in   [num_clients] level request, held until that client's ack
//   cli_a    in   [num_clients*float_width] operand a, client i at
//                 [i*float_width +: float_width]
//   cli_b    in   [num_clients*float_width] operand b, same packing
//   cli_ack  out  [num_clients] one-hot single-cycle result strobe
//   cli_out  out  [float_width] result, non-zero only alongside cli_ack
//   cli_err  out  [num_clients] one-hot single-cycle timeout strobe
//   fa_req   out  request to the adder, high for exactly one cycle
//   fa_a     out  [float_width] operand a to the adder (held until next grant)
//   fa_b     out  [float_width] operand b to the adder (held until next grant)
//   fa_out   in   [float_width] adder result
//   fa_ack   in   adder result strobe
//   busy     out  high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module float_add_arbiter #(
    parameter int num_clients    = 4,
    parameter int float_width    = 32,
    parameter int timeout_cycles = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [num_clients-1:0]             cli_req,
    input  logic [num_clients*float_width-1:0] cli_a,
    input  logic [num_clients*float_width-1:0] cli_b,
    output logic [num_clients-1:0]             cli_ack,
    output logic [float_width-1:0]             cli_out,
    output logic [num_clients-1:0]             cli_err,
    output logic                               fa_req,
    output logic [float_width-1:0]             fa_a,
    output logic [float_width-1:0]             fa_b,
    input  logic [float_width-1:0]             fa_out,
    input  logic                               fa_ack,
    output logic                               busy
);

    localparam int IDX_W = $clog2(num_clients);

    if (num_clients < 2 || num_clients > 16 || timeout_cycles < 1) begin : g_param_check
        $error("float_add_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state_q,   state_d;
    logic [IDX_W-1:0]         rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]         grant_q,   grant_d;
    logic                     fa_req_q,  fa_req_d;
    logic [float_width-1:0]   fa_a_q,    fa_a_d;
    logic [float_width-1:0]   fa_b_q,    fa_b_d;
    logic [num_clients-1:0]   cli_ack_q, cli_ack_d;
    logic [float_width-1:0]   cli_out_q, cli_out_d;

`ifdef FLOAT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(timeout_cycles + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(timeout_cycles - 1);

    logic [TW-1:0]            timer_q,   timer_d;
    logic [num_clients-1:0]   cli_err_q, cli_err_d;
`endif

    // Per-client operand views of the flattened buses.
    logic [float_width-1:0]   a_arr [num_clients];
    logic [float_width-1:0]   b_arr [num_clients];

    always_comb begin
        for (int i = 0; i < num_clients; i++) begin
            a_arr[i] = cli_a[i*float_width +: float_width];
            b_arr[i] = cli_b[i*float_width +: float_width];
        end
    end

    // A client being acked this cycle still shows its request (it sees the
    // ack only next cycle), so it is masked out to avoid a stale re-grant.
    logic [num_clients-1:0]   masked_req;
    logic                     found;
    logic [IDX_W-1:0]         pick;

    always_comb begin
        int idx;
        masked_req = cli_req & ~cli_ack_q;
        found      = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int k = 0; k < num_clients; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= num_clients) begin
                idx = idx - num_clients;
            end
            if (!found && masked_req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    logic [num_clients-1:0]   grant_onehot;
    logic [IDX_W-1:0]         ptr_after_grant;

    assign grant_onehot    = num_clients'(1) << grant_q;
    assign ptr_after_grant = (grant_q == IDX_W'(num_clients - 1)) ? '0
                                                                   : grant_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        fa_req_d  = 1'b0;
        fa_a_d    = fa_a_q;
        fa_b_d    = fa_b_q;
        cli_ack_d = '0;
        cli_out_d = '0;
`ifdef FLOAT_ARB_TIMEOUT_EN
        timer_d   = timer_q;
        cli_err_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    fa_a_d   = a_arr[pick];
                    fa_b_d   = b_arr[pick];
                    fa_req_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FLOAT_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            WAIT: begin
                if (fa_ack) begin
                    cli_out_d = fa_out;
                    cli_ack_d = grant_onehot;
                    rr_ptr_d  = ptr_after_grant;
                    state_d   = IDLE;
                end
`ifdef FLOAT_ARB_TIMEOUT_EN
                // The counter holds the number of WAIT cycles already spent,
                // so the error is registered on the timeout_cycles-th one.
                else if (timer_q == TIMER_LAST) begin
                    cli_err_d = grant_onehot;
                    rr_ptr_d  = ptr_after_grant;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            fa_req_q  <= 1'b0;
            fa_a_q    <= '0;
            fa_b_q    <= '0;
            cli_ack_q <= '0;
            cli_out_q <= '0;
`ifdef FLOAT_ARB_TIMEOUT_EN
            timer_q   <= '0;
            cli_err_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            fa_req_q  <= fa_req_d;
            fa_a_q    <= fa_a_d;
            fa_b_q    <= fa_b_d;
            cli_ack_q <= cli_ack_d;
            cli_out_q <= cli_out_d;
`ifdef FLOAT_ARB_TIMEOUT_EN
            timer_q   <= timer_d;
            cli_err_q <= cli_err_d;
`endif
        end
    end

    assign cli_ack = cli_ack_q;
    assign cli_out = cli_out_q;
    assign fa_req  = fa_req_q;
    assign fa_a    = fa_a_q;
    assign fa_b    = fa_b_q;
    assign busy    = (state_q != IDLE);

`ifdef FLOAT_ARB_TIMEOUT_EN
    assign cli_err = cli_err_q;
`else
    assign cli_err = '0;
`endif

endmodule

// File: tb/tb_float_add_arbiter.sv
module tb_float_add_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     cli_req;
    logic [N*W-1:0]   cli_a;
    logic [N*W-1:0]   cli_b;
    logic [N-1:0]     cli_ack;
    logic [W-1:0]     cli_out;
    logic [N-1:0]     cli_err;
    logic             fa_req;
    logic [W-1:0]     fa_a;
    logic [W-1:0]     fa_b;
    logic [W-1:0]     fa_out = '0;
    logic             fa_ack = 1'b0;
    logic             busy;

    int total = 0;
    int bad   = 0;

    float_add_arbiter #(
        .num_clients   (N),
        .float_width   (W),
        .timeout_cycles(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cli_req (cli_req),
        .cli_a   (cli_a),
        .cli_b   (cli_b),
        .cli_ack (cli_ack),
        .cli_out (cli_out),
        .cli_err (cli_err),
        .fa_req  (fa_req),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_out  (fa_out),
        .fa_ack  (fa_ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Adder behaviour: known float sums for the directed pairs, an arbitrary
    // deterministic mix otherwise (the arbiter only forwards the value).
    function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3f800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3fc00000 && b == 32'h40200000) return 32'h40800000;
        if (a == 32'h3f800000 && b == 32'h3f800000) return 32'h40000000;
        if (a == 32'h3f000000 && b == 32'h3f000000) return 32'h3f800000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a0001;
    endfunction

    // Adder stub: acks a fixed 3 (or random 1..6) cycles after seeing fa_req.
    int  stub_cnt  = 0;
    bit  stub_pend = 1'b0;
    bit  stub_mute = 1'b0;
    bit  stub_rand = 1'b0;

    always @(negedge clk) begin
        fa_ack = 1'b0;
        fa_out = '0;
        if (!rst) begin
            stub_pend = 1'b0;
        end else if (fa_req) begin
            stub_pend = !stub_mute;
            stub_cnt  = stub_rand ? int'($urandom_range(1, 6)) : 3;
        end else if (stub_pend) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                fa_ack    = 1'b1;
                fa_out    = fadd(fa_a, fa_b);
                stub_pend = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        cli_a[i*W +: W] = a;
        cli_b[i*W +: W] = b;
    endtask

    task automatic quiet_chk(input string tag);
        chk({tag, "_fa_req"},  fa_req,  '0);
        chk({tag, "_cli_ack"}, cli_ack, '0);
        chk({tag, "_cli_out"}, cli_out, '0);
        chk({tag, "_cli_err"}, cli_err, '0);
        chk({tag, "_busy"},    busy,    '0);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        cli_req = '0;
        cli_a   = '0;
        cli_b   = '0;
        repeat (2) @(negedge clk);
        quiet_chk("rst");
        chk("rst_fa_a", fa_a, '0);
        chk("rst_fa_b", fa_b, '0);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_ack;
        logic [W-1:0] exp_out;
        logic [N-1:0] pend_prev;
        logic [N-1:0] ack_now;
        logic         busy_prev;
        logic [W-1:0] pa [N];
        logic [W-1:0] pb [N];
        logic [W-1:0] exp_r;
        int           ptr;
        int           w;
        int           exp_c;
        int           wait_cnt;
        int           acks;
        bit           exp_v;

        // Reset, then idle with no requests.
        do_reset();
        repeat (3) begin
            @(negedge clk);
            quiet_chk("idle");
        end

        // Single add from client 2: fa_req in cycle 1, ack and result in cycle 5.
        cli_req[2] = 1'b1;
        set_ops(2, 32'h3f800000, 32'h40000000);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("single_fa_req", fa_req, (c == 1));
            chk("single_ack", cli_ack, (c == 5) ? 4'b0100 : 4'b0000);
            chk("single_out", cli_out, (c == 5) ? 32'h40400000 : 32'h0);
            chk("single_busy", busy, (c >= 1 && c <= 4));
            if (c == 1) begin
                chk("single_fa_a", fa_a, 32'h3f800000);
                chk("single_fa_b", fa_b, 32'h40000000);
            end
            if (c == 5) cli_req[2] = 1'b0;
        end

        // Contention between clients 0, 1 and 3: acks 0,1,3 five cycles apart.
        do_reset();
        cli_req = 4'b1011;
        set_ops(0, 32'h3fc00000, 32'h40200000);
        set_ops(1, 32'h3f800000, 32'h3f800000);
        set_ops(3, 32'h3f000000, 32'h3f000000);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            exp_ack = (c == 5) ? 4'b0001 : (c == 10) ? 4'b0010 : (c == 15) ? 4'b1000 : 4'b0000;
            exp_out = (c == 5) ? 32'h40800000 : (c == 10) ? 32'h40000000 :
                      (c == 15) ? 32'h3f800000 : 32'h0;
            chk("cont_ack", cli_ack, exp_ack);
            chk("cont_out", cli_out, exp_out);
            chk("cont_fa_req", fa_req, (c == 1 || c == 6 || c == 11));
            chk("cont_busy", busy, (c % 5 != 0) && (c < 15));
            cli_req = cli_req & ~exp_ack;
        end

        // Reset during WAIT abandons client 1's add; it is re-granted afterwards.
        do_reset();
        cli_req[1] = 1'b1;
        set_ops(1, 32'h3f800000, 32'h3f800000);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk("mrst_fa_req", fa_req, (c == 1 || c == 6));
            chk("mrst_ack", cli_ack, (c == 10) ? 4'b0010 : 4'b0000);
            chk("mrst_out", cli_out, (c == 10) ? 32'h40000000 : 32'h0);
            if (c == 4 || c == 5) chk("mrst_busy", busy, 1'b0);
            if (c == 6) chk("mrst_fa_a", fa_a, 32'h3f800000);
            if (c == 3) rst = 1'b0;
            if (c == 5) rst = 1'b1;
            if (c == 10) cli_req[1] = 1'b0;
        end

        // Client 0 keeps cli_req high through its ack cycle: only one ack.
        do_reset();
        cli_req[0] = 1'b1;
        set_ops(0, 32'h3fc00000, 32'h40200000);
        acks = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (cli_ack != 0) acks++;
            chk("mask_fa_req", fa_req, (c == 1));
            chk("mask_ack", cli_ack, (c == 5) ? 4'b0001 : 4'b0000);
            if (c == 6) cli_req[0] = 1'b0;
        end
        chk("mask_ack_count", acks, 1);

`ifdef FLOAT_ARB_TIMEOUT_EN
        // Silent adder: error strobe TO cycles after entering WAIT (cycle 2).
        do_reset();
        stub_mute  = 1'b1;
        cli_req[3] = 1'b1;
        set_ops(3, 32'h12345678, 32'h9abcdef0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("to_err", cli_err, (c == TO + 2) ? 4'b1000 : 4'b0000);
            chk("to_ack", cli_ack, '0);
            chk("to_fa_req", fa_req, (c == 1));
            chk("to_busy", busy, (c >= 1 && c < TO + 2));
            if (c == TO + 2) cli_req[3] = 1'b0;
        end
        stub_mute = 1'b0;
`endif

        // Random traffic against a transaction-level round-robin model.
        do_reset();
        stub_rand = 1'b1;
        pend_prev = '0;
        busy_prev = 1'b0;
        ptr       = 0;
        exp_v     = 1'b0;
        exp_c     = 0;
        exp_r     = '0;
        wait_cnt  = 0;
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            chk("rnd_fa_req", fa_req, (!busy_prev && pend_prev != 0));
            if (fa_req) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && pend_prev[(ptr + k) % N]) w = (ptr + k) % N;
                end
                if (w < 0) w = 0;
                chk("rnd_fa_a", fa_a, pa[w]);
                chk("rnd_fa_b", fa_b, pb[w]);
                exp_v    = 1'b1;
                exp_c    = w;
                exp_r    = fadd(pa[w], pb[w]);
                wait_cnt = 0;
            end
            if (cli_ack != 0) begin
                chk("rnd_ack_expected", exp_v, 1'b1);
                chk("rnd_ack", cli_ack, 4'b0001 << exp_c);
                chk("rnd_out", cli_out, exp_r);
                ptr   = (exp_c + 1) % N;
                exp_v = 1'b0;
            end else begin
                chk("rnd_out_idle", cli_out, '0);
            end
            chk("rnd_busy", busy, exp_v);
            chk("rnd_err", cli_err, '0);
            if (exp_v) begin
                wait_cnt++;
                chk("rnd_ack_bound", (wait_cnt <= 20), 1'b1);
            end

            ack_now = cli_ack;
            for (int i = 0; i < N; i++) begin
                if (ack_now[i]) begin
                    if ($urandom_range(0, 1) == 0) cli_req[i] = 1'b0;
                    else set_ops(i, $urandom(), $urandom());
                end else if (!cli_req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cli_req[i] = 1'b1;
                        set_ops(i, $urandom(), $urandom());
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    set_ops(i, $urandom(), $urandom());
                end
            end
            pend_prev = cli_req & ~ack_now;
            busy_prev = busy;
            for (int i = 0; i < N; i++) begin
                pa[i] = cli_a[i*W +: W];
                pb[i] = cli_b[i*W +: W];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
